bpu_gshare: RTL and testbench

Parametrised branch prediction unit for the 5-stage pipeline: a direct-mapped branch target buffer plus a 2-bit counter history table, with a runtime-selectable bimodal or gshare index mode and a speculative global history register. The fetch stage reads it in the same cycle. The memory stage resolves each branch, trains the tables and repairs the history. It adds a preload port for table initialisation and saturating statistics counters.

---
 rtl/bpu_gshare.sv | 151 +++++++++++++++
 tb/tb_bpu_gshare.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bpu_gshare.sv
// Branch predictor: direct-mapped BTB plus 2-bit counter table, bimodal or gshare indexed, speculative GHR.
// Latency: lookup and mispredict/redirect are combinational; table, history and stat writes land on the next edge.
// Backpressure: none; lk_stall only freezes the speculative history, preload writes take priority over training.
module bpu_gshare #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 256,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 8,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_addr,
  input  logic             init_valid,
  input  logic [TAG_W-1:0] init_tag,
  input  logic [XLEN-1:0]  init_target,
  input  logic [1:0]       init_ctr,
  input  logic             lk_valid,
  input  logic             lk_stall,
  input  logic [XLEN-1:0]  lk_pc,
  output logic             lk_hit,
  output logic             lk_taken,
  output logic [XLEN-1:0]  lk_target,
  output logic [GHR_W-1:0] lk_ghr,
  input  logic             up_valid,
  input  logic             up_is_branch,
  input  logic             up_taken,
  input  logic [XLEN-1:0]  up_pc,
  input  logic [XLEN-1:0]  up_target,
  input  logic             up_pred_taken,
  input  logic [XLEN-1:0]  up_pred_target,
  input  logic [GHR_W-1:0] up_ghr,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } btb_dat_t;

  btb_dat_t                    btb_dat [ENTRIES];
  logic [ENTRIES-1:0]          btb_vld;
  logic [ENTRIES-1:0][1:0]     bht;
  logic [GHR_W-1:0]            ghr;
  logic [31:0]                 br_cnt;
  logic [31:0]                 mis_cnt;

  function automatic logic [IDX_W-1:0] bim_idx(input logic [XLEN-1:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [IDX_W-1:0] bht_idx(input logic [XLEN-1:0] pc,
                                               input logic [GHR_W-1:0] h,
                                               input logic             gs);
    return bim_idx(pc) ^ (gs ? IDX_W'(h) : '0);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [XLEN-1:0] pc);
    return pc[IDX_W+2 +: TAG_W];
  endfunction

  logic [IDX_W-1:0] lk_bi, lk_gi, up_bi, up_gi;
  logic             up_br, up_alias;
  logic [1:0]       ctr_cur, ctr_nxt;

  assign lk_bi = bim_idx(lk_pc);
  assign lk_gi = bht_idx(lk_pc, ghr, mode);
  assign up_bi = bim_idx(up_pc);
  assign up_gi = bht_idx(up_pc, up_ghr, mode);

  assign lk_hit    = btb_vld[lk_bi] && (btb_dat[lk_bi].tag == tag_of(lk_pc));
  assign lk_taken  = lk_hit & bht[lk_gi][1];
  assign lk_target = lk_hit ? btb_dat[lk_bi].target : '0;
  assign lk_ghr    = ghr;

  assign up_br    = up_valid & up_is_branch;
  assign up_alias = up_valid & ~up_is_branch & up_pred_taken;

  assign mispredict = up_valid & ((up_is_branch & (up_taken != up_pred_taken)) |
                                  (up_is_branch & up_taken & (up_target != up_pred_target)) |
                                  (~up_is_branch & up_pred_taken));
  assign redirect_pc = (up_is_branch & up_taken) ? up_target : up_pc + XLEN'(4);

  assign stat_branches    = br_cnt;
  assign stat_mispredicts = mis_cnt;

  always_comb begin
    ctr_cur = bht[up_gi];
    ctr_nxt = ctr_cur;
    if (up_taken && ctr_cur != 2'd3)
      ctr_nxt = ctr_cur + 2'd1;
    else if (!up_taken && ctr_cur != 2'd0)
      ctr_nxt = ctr_cur - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_vld <= '0;
      bht     <= {ENTRIES{2'b01}};
    end else if (init_en) begin
      btb_vld[init_addr] <= init_valid;
      bht[init_addr]     <= init_ctr;
    end else if (up_br) begin
      bht[up_gi] <= ctr_nxt;
      if (up_taken)
        btb_vld[up_bi] <= 1'b1;
    end else if (up_alias) begin
      btb_vld[up_bi] <= 1'b0;
    end
  end

  // Tag/target payload is qualified by btb_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (init_en)
      btb_dat[init_addr] <= '{tag: init_tag, target: init_target};
    else if (up_br && up_taken)
      btb_dat[up_bi] <= '{tag: tag_of(up_pc), target: up_target};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ghr <= '0;
    else if (init_en)
      ghr <= '0;
    else if (mispredict)
      ghr <= up_is_branch ? ((up_ghr << 1) | GHR_W'(up_taken)) : up_ghr;
    else if (lk_valid && !lk_stall && lk_hit)
      ghr <= (ghr << 1) | GHR_W'(lk_taken);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (up_br && br_cnt != 32'hFFFF_FFFF)
        br_cnt <= br_cnt + 32'd1;
      if (mispredict && mis_cnt != 32'hFFFF_FFFF)
        mis_cnt <= mis_cnt + 32'd1;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], lk_pc[XLEN-1:IDX_W+2+TAG_W]};

endmodule

// File: tb/tb_bpu_gshare.sv
// Directed bench for bpu_gshare: reset, bimodal/gshare training, history repair, alias, priority and saturation.
module tb_bpu_gshare;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        init_en;
  logic [7:0]  init_addr;
  logic        init_valid;
  logic [7:0]  init_tag;
  logic [31:0] init_target;
  logic [1:0]  init_ctr;
  logic        lk_valid, lk_stall;
  logic [31:0] lk_pc;
  logic        lk_hit, lk_taken;
  logic [31:0] lk_target;
  logic [7:0]  lk_ghr;
  logic        up_valid, up_is_branch, up_taken, up_pred_taken;
  logic [31:0] up_pc, up_target, up_pred_target;
  logic [7:0]  up_ghr;
  logic        mispredict;
  logic [31:0] redirect_pc, stat_branches, stat_mispredicts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bpu_gshare dut (
    .clk(clk), .rst(rst), .mode(mode),
    .init_en(init_en), .init_addr(init_addr), .init_valid(init_valid),
    .init_tag(init_tag), .init_target(init_target), .init_ctr(init_ctr),
    .lk_valid(lk_valid), .lk_stall(lk_stall), .lk_pc(lk_pc),
    .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target), .lk_ghr(lk_ghr),
    .up_valid(up_valid), .up_is_branch(up_is_branch), .up_taken(up_taken),
    .up_pc(up_pc), .up_target(up_target), .up_pred_taken(up_pred_taken),
    .up_pred_target(up_pred_target), .up_ghr(up_ghr),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic br, input logic tk, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic [7:0] gh);
    up_valid = 1'b1; up_is_branch = br; up_taken = tk; up_pc = pc;
    up_target = tgt; up_pred_taken = ptk; up_pred_target = ptgt; up_ghr = gh;
  endtask

  task automatic preload(input logic [7:0] a, input logic v, input logic [7:0] t,
                         input logic [31:0] tgt, input logic [1:0] c);
    init_en = 1'b1; init_addr = a; init_valid = v; init_tag = t;
    init_target = tgt; init_ctr = c;
  endtask

  initial begin
    rst = 1'b0; mode = 1'b0; init_en = 1'b0; init_addr = '0; init_valid = 1'b0;
    init_tag = '0; init_target = '0; init_ctr = '0; lk_valid = 1'b0; lk_stall = 1'b0;
    lk_pc = 32'h100; up_valid = 1'b0; up_is_branch = 1'b0; up_taken = 1'b0;
    up_pc = '0; up_target = '0; up_pred_taken = 1'b0; up_pred_target = '0; up_ghr = '0;

    #2;
    check("rst_hit", lk_hit, 0);
    check("rst_taken", lk_taken, 0);
    check("rst_target", lk_target, 0);
    check("rst_ghr", lk_ghr, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_stats", {stat_branches, stat_mispredicts}, 0);
    #10 rst = 1'b1;
    tick();
    check("first_lookup_miss", lk_hit, 0);

    // Bimodal training: two taken resolutions predicted not-taken.
    resolve(1, 1, 32'h100, 32'h200, 0, 32'h0, 8'h00);
    #1;
    check("bim_mp1", mispredict, 1);
    check("bim_redir1", redirect_pc, 32'h200);
    tick();
    check("bim_mp2", mispredict, 1);
    check("bim_redir2", redirect_pc, 32'h200);
    tick();
    up_valid = 1'b0;
    #1;
    check("bim_hit", lk_hit, 1);
    check("bim_taken", lk_taken, 1);
    check("bim_target", lk_target, 32'h200);
    check("bim_stat_br", stat_branches, 2);
    check("bim_stat_mp", stat_mispredicts, 2);

    // Gshare: pc 0x400 -> btb idx 0, tag 1; counters at 0,1,3,7 preloaded strongly taken.
    preload(8'h00, 1, 8'h01, 32'h500, 2'd3); tick();
    preload(8'h01, 0, 8'h00, 32'h0, 2'd3);   tick();
    preload(8'h03, 0, 8'h00, 32'h0, 2'd3);   tick();
    preload(8'h07, 0, 8'h00, 32'h0, 2'd3);   tick();
    init_en = 1'b0; mode = 1'b1; lk_valid = 1'b1; lk_pc = 32'h400;
    #1;
    check("gs_ghr_after_init", lk_ghr, 0);
    check("gs_hit0", {lk_hit, lk_taken}, 2'b11);
    check("gs_target0", lk_target, 32'h500);
    tick(); tick(); tick();
    check("gs_taken3", lk_taken, 1);
    tick();
    lk_valid = 1'b0;
    #1;
    check("gs_ghr_0f", lk_ghr, 8'h0F);
    resolve(1, 0, 32'h400, 32'h500, 1, 32'h500, 8'h03);
    #1;
    check("gs_mp", mispredict, 1);
    check("gs_redir", redirect_pc, 32'h404);
    tick();
    up_valid = 1'b0;
    #1;
    check("gs_repair", lk_ghr, 8'h06);

    // Repair beats speculative shift in the same cycle.
    lk_valid = 1'b1;
    resolve(1, 1, 32'h400, 32'h500, 0, 32'h0, 8'h05);
    #1;
    check("sc_lookup_hit", lk_hit, 1);
    tick();
    up_valid = 1'b0; lk_valid = 1'b0;
    #1;
    check("sc_repair_wins", lk_ghr, 8'h0B);
    check("sc_stat_mp", stat_mispredicts, 4);

    // Alias: install 0x300, then resolve it as a non-branch predicted taken.
    mode = 1'b0; lk_pc = 32'h300;
    resolve(1, 1, 32'h300, 32'h380, 0, 32'h0, 8'h00);
    tick();
    up_valid = 1'b0;
    #1;
    check("alias_pre_hit", lk_hit, 1);
    resolve(0, 0, 32'h300, 32'h0, 1, 32'h380, 8'h00);
    #1;
    check("alias_mp", mispredict, 1);
    check("alias_redir", redirect_pc, 32'h304);
    tick();
    up_valid = 1'b0;
    #1;
    check("alias_cleared", lk_hit, 0);
    check("alias_stats", {stat_branches, stat_mispredicts}, {32'd5, 32'd6});

    // Preload and training to the same entry: preload wins.
    lk_pc = 32'h100;
    resolve(1, 1, 32'h100, 32'h600, 1, 32'h600, 8'h00);
    preload(8'h40, 1, 8'h00, 32'h700, 2'd0);
    #1;
    check("init_upd_no_mp", mispredict, 0);
    tick();
    init_en = 1'b0; up_valid = 1'b0;
    #1;
    check("init_wins_target", lk_target, 32'h700);
    check("init_wins_ctr", lk_taken, 0);
    check("init_clears_ghr", lk_ghr, 0);

    // Counter saturation: 0 -> 3 and held, then down.
    resolve(1, 1, 32'h100, 32'h700, 1, 32'h700, 8'h00);
    repeat (5) tick();
    up_valid = 1'b0;
    #1;
    check("sat_taken_after5", lk_taken, 1);
    resolve(1, 0, 32'h100, 32'h700, 1, 32'h700, 8'h00);
    tick();
    up_valid = 1'b0;
    #1;
    check("sat_ctr2_taken", lk_taken, 1);
    resolve(1, 0, 32'h100, 32'h700, 1, 32'h700, 8'h00);
    tick();
    up_valid = 1'b0;
    #1;
    check("sat_ctr1_not_taken", lk_taken, 0);
    check("sat_stats", {stat_branches, stat_mispredicts}, {32'd13, 32'd8});

    // Statistics saturation.
    force dut.mis_cnt = 32'hFFFF_FFFE;
    #1 release dut.mis_cnt;
    resolve(0, 0, 32'h800, 32'h0, 1, 32'h0, 8'h00);
    tick();
    check("stat_reach_max", stat_mispredicts, 32'hFFFF_FFFF);
    tick(); tick();
    check("stat_hold_max", stat_mispredicts, 32'hFFFF_FFFF);
    up_valid = 1'b0;

    // Mid-operation reset clears state immediately.
    lk_pc = 32'h100;
    #2 rst = 1'b0;
    #1;
    check("midrst_hit", lk_hit, 0);
    check("midrst_stats", {stat_branches, stat_mispredicts}, 0);
    tick();
    rst = 1'b1;
    tick();
    check("postrst_miss", {lk_hit, lk_target}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
